// File: rtl/spi_power_seq_if.sv
// Event log strobe interface of spi_power_seq: one-cycle event byte plus sticky overrun flag.
interface spi_power_seq_if;
    logic       log_strobe;
    logic [7:0] log_val;
    logic       overrun;
    logic       overrun_clear;

    modport master (
        output log_strobe,
        output log_val,
        output overrun,
        input  overrun_clear
    );

    modport slave (
        input  log_strobe,
        input  log_val,
        input  overrun,
        output overrun_clear
    );
endinterface

// File: rtl/spi_power_seq.sv
// Per-channel power-pin synchroniser, reset-hold sequencer and power event logger.
// Define SPI_PWR_GLITCH_FILTER_EN to build the DROP-state filter for short power losses.
module spi_power_seq #(
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned HOLD_CYCLES = 65536,
    parameter int unsigned DROP_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] spi_power_in,
    output logic [CHANNELS-1:0] spi_reset,
    output logic [CHANNELS-1:0] spi_power_ok,
    spi_power_seq_if.master     log_if
);

    localparam int unsigned MaxCnt = (HOLD_CYCLES > DROP_CYCLES) ? HOLD_CYCLES : DROP_CYCLES;
    localparam int unsigned CntW   = $clog2(MaxCnt);

    typedef enum logic [1:0] {
        StOff,
        StRamp,
        StOn
`ifdef SPI_PWR_GLITCH_FILTER_EN
        , StDrop
`endif
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q [CHANNELS];
    state_e                 state_q [CHANNELS];
    state_e                 state_d [CHANNELS];
    logic [CntW-1:0]        cnt_q [CHANNELS];
    logic [CntW-1:0]        cnt_d [CHANNELS];

    logic [CHANNELS-1:0] pend_up_q, pend_up_d, pend_dn_q, pend_dn_d;
    logic [CHANNELS-1:0] set_up, set_dn, grant_up, grant_dn;
    logic                gnt_any, gnt_is_up, lost;
    logic [2:0]          gnt_chan;
    logic                log_strobe_q, log_strobe_d, overrun_q, overrun_d;
    logic [7:0]          log_val_q, log_val_d;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            spi_power_ok[i] = sync_q[i][SYNC_STAGES-1];
            spi_reset[i]    = (state_q[i] == StOff) || (state_q[i] == StRamp);
        end
    end

    always_comb begin
        set_up = '0;
        set_dn = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                StOff: begin
                    if (spi_power_ok[i]) begin
                        state_d[i] = StRamp;
                        cnt_d[i]   = '0;
                    end
                end
                StRamp: begin
                    if (!spi_power_ok[i]) begin
                        state_d[i] = StOff;
                    end else if (cnt_q[i] == CntW'(HOLD_CYCLES - 1)) begin
                        state_d[i] = StOn;
                        set_up[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                StOn: begin
                    if (!spi_power_ok[i]) begin
`ifdef SPI_PWR_GLITCH_FILTER_EN
                        state_d[i] = StDrop;
                        cnt_d[i]   = '0;
`else
                        state_d[i] = StOff;
                        set_dn[i]  = 1'b1;
`endif
                    end
                end
`ifdef SPI_PWR_GLITCH_FILTER_EN
                StDrop: begin
                    if (spi_power_ok[i]) begin
                        state_d[i] = StOn;
                    end else if (cnt_q[i] == CntW'(DROP_CYCLES - 1)) begin
                        state_d[i] = StOff;
                        set_dn[i]  = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
`endif
                default: state_d[i] = StOff;
            endcase
        end
    end

    // Lowest channel wins; within a channel the up event goes first.
    always_comb begin
        grant_up  = '0;
        grant_dn  = '0;
        gnt_any   = 1'b0;
        gnt_is_up = 1'b0;
        gnt_chan  = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (!gnt_any && (pend_up_q[i] || pend_dn_q[i])) begin
                gnt_any  = 1'b1;
                gnt_chan = 3'(i);
                if (pend_up_q[i]) begin
                    grant_up[i] = 1'b1;
                    gnt_is_up   = 1'b1;
                end else begin
                    grant_dn[i] = 1'b1;
                end
            end
        end
    end

    // A fresh event on a bit being granted this cycle survives; on a waiting bit it is lost.
    always_comb begin
        pend_up_d    = (pend_up_q & ~grant_up) | set_up;
        pend_dn_d    = (pend_dn_q & ~grant_dn) | set_dn;
        lost         = |((set_up & pend_up_q & ~grant_up) | (set_dn & pend_dn_q & ~grant_dn));
        overrun_d    = lost ? 1'b1 : (log_if.overrun_clear ? 1'b0 : overrun_q);
        log_strobe_d = gnt_any;
        log_val_d    = gnt_any ? {2'b10, gnt_is_up, 2'b00, gnt_chan} : log_val_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= '0;
                state_q[i] <= StOff;
                cnt_q[i]   <= '0;
            end
            pend_up_q    <= '0;
            pend_dn_q    <= '0;
            log_strobe_q <= 1'b0;
            log_val_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                sync_q[i]  <= {sync_q[i][SYNC_STAGES-2:0], spi_power_in[i]};
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_up_q    <= pend_up_d;
            pend_dn_q    <= pend_dn_d;
            log_strobe_q <= log_strobe_d;
            log_val_q    <= log_val_d;
            overrun_q    <= overrun_d;
        end
    end

    assign log_if.log_strobe = log_strobe_q;
    assign log_if.log_val    = log_val_q;
    assign log_if.overrun    = overrun_q;

endmodule

// File: tb/tb_spi_power_seq.sv
// Directed bench for spi_power_seq: three instances covering 1, 4 and 8 channels.
module tb_spi_power_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic       rst1, rst4, rst8;
    logic [0:0] pin1, sr1, ok1;
    logic [3:0] pin4, sr4, ok4;
    logic [7:0] pin8, sr8, ok8;
    logic       seen, sr_any;

    spi_power_seq_if if1 ();
    spi_power_seq_if if4 ();
    spi_power_seq_if if8 ();

    spi_power_seq #(.CHANNELS(1), .SYNC_STAGES(2), .HOLD_CYCLES(8), .DROP_CYCLES(16)) u_dut1 (
        .clk(clk), .reset(rst1), .spi_power_in(pin1), .spi_reset(sr1), .spi_power_ok(ok1),
        .log_if(if1)
    );
    spi_power_seq #(.CHANNELS(4), .SYNC_STAGES(2), .HOLD_CYCLES(8), .DROP_CYCLES(16)) u_dut4 (
        .clk(clk), .reset(rst4), .spi_power_in(pin4), .spi_reset(sr4), .spi_power_ok(ok4),
        .log_if(if4)
    );
    spi_power_seq #(.CHANNELS(8), .SYNC_STAGES(2), .HOLD_CYCLES(2), .DROP_CYCLES(2)) u_dut8 (
        .clk(clk), .reset(rst8), .spi_power_in(pin8), .spi_reset(sr8), .spi_power_ok(ok8),
        .log_if(if8)
    );

    // Log stream monitor for the 8-channel instance.
    logic [7:0]  up_seen8 = '0;
    int unsigned order_err8 = 0;
    int unsigned tag_err8 = 0;
    int unsigned strobes8 = 0;
    always @(negedge clk) begin
        if (!rst8 && if8.log_strobe) begin
            strobes8 <= strobes8 + 1;
            if (if8.log_val[7:6] != 2'b10 || if8.log_val[4:3] != 2'b00) tag_err8 <= tag_err8 + 1;
            if (if8.log_val[5]) up_seen8[if8.log_val[2:0]] <= 1'b1;
            else if (!up_seen8[if8.log_val[2:0]]) order_err8 <= order_err8 + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst1 = 1'b1; rst4 = 1'b1; rst8 = 1'b1;
        pin1 = '0; pin4 = '0; pin8 = '0;
        if1.overrun_clear = 1'b0; if4.overrun_clear = 1'b0; if8.overrun_clear = 1'b0;
        repeat (3) tick();
        check("rst_spi_reset", 32'(sr1), 32'h1);
        check("rst_power_ok", 32'(ok1), 32'h0);
        check("rst_strobe", 32'(if1.log_strobe), 32'h0);
        check("rst_val", 32'(if1.log_val), 32'h0);
        check("rst_overrun", 32'(if1.overrun), 32'h0);
        check("rst_spi_reset4", 32'(sr4), 32'hF);
        check("rst_spi_reset8", 32'(sr8), 32'hFF);

        // Power-up: reset falls 11 edges after the pin rises, event one edge later.
        rst1 = 1'b0; pin1 = 1'b1;
        repeat (2) tick();
        check("sync_latency", 32'(ok1), 32'h1);
        repeat (8) tick();
        check("hold_edge10", 32'(sr1), 32'h1);
        tick();
        check("hold_edge11", 32'(sr1), 32'h0);
        check("no_strobe_edge11", 32'(if1.log_strobe), 32'h0);
        tick();
        check("up_strobe", 32'(if1.log_strobe), 32'h1);
        check("up_val", 32'(if1.log_val), 32'hA0);
        tick();
        check("up_strobe_single", 32'(if1.log_strobe), 32'h0);

`ifdef SPI_PWR_GLITCH_FILTER_EN
        pin1 = 1'b0; seen = 1'b0; sr_any = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(); seen |= if1.log_strobe; sr_any |= sr1[0];
        end
        pin1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick(); seen |= if1.log_strobe; sr_any |= sr1[0];
        end
        check("glitch_reset_held_low", 32'(sr_any), 32'h0);
        check("glitch_no_log", 32'(seen), 32'h0);
        pin1 = 1'b0;
        repeat (18) tick();
        check("drop_edge18", 32'(sr1), 32'h0);
        tick();
        check("drop_edge19", 32'(sr1), 32'h1);
`else
        pin1 = 1'b0;
        repeat (2) tick();
        check("drop_edge2", 32'(sr1), 32'h0);
        tick();
        check("drop_edge3", 32'(sr1), 32'h1);
`endif
        tick();
        check("dn_strobe", 32'(if1.log_strobe), 32'h1);
        check("dn_val", 32'(if1.log_val), 32'h80);
        tick();
        check("dn_strobe_single", 32'(if1.log_strobe), 32'h0);

        // Power lost during RAMP: no event and the hold restarts from the second rise.
        pin1 = 1'b1; seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); seen |= if1.log_strobe;
        end
        pin1 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick(); seen |= if1.log_strobe;
        end
        check("ramp_drop_reset", 32'(sr1), 32'h1);
        pin1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(); seen |= if1.log_strobe;
        end
        check("ramp_edge10", 32'(sr1), 32'h1);
        check("ramp_no_log", 32'(seen), 32'h0);
        tick();
        check("ramp_edge11", 32'(sr1), 32'h0);

        // Reset with an up event pending: discarded, then the full hold repeats.
        rst1 = 1'b1;
        tick();
        check("midrst_spi_reset", 32'(sr1), 32'h1);
        check("midrst_strobe", 32'(if1.log_strobe), 32'h0);
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(); seen |= if1.log_strobe;
        end
        rst1 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(); seen |= if1.log_strobe;
        end
        check("midrst_no_strobe", 32'(seen), 32'h0);
        check("rehold_edge10", 32'(sr1), 32'h1);
        tick();
        check("rehold_edge11", 32'(sr1), 32'h0);
        tick();
        check("rehold_strobe", 32'(if1.log_strobe), 32'h1);
        check("rehold_val", 32'(if1.log_val), 32'hA0);
        check("dut1_no_overrun", 32'(if1.overrun), 32'h0);

        // Four channels rising together drain on consecutive cycles, lowest first.
        rst4 = 1'b0; pin4 = 4'hF;
        repeat (10) tick();
        check("multi_edge10", 32'(sr4), 32'hF);
        tick();
        check("multi_edge11", 32'(sr4), 32'h0);
        for (int c = 0; c < 4; c++) begin
            tick();
            check("multi_strobe", 32'(if4.log_strobe), 32'h1);
            check("multi_val", 32'(if4.log_val), 32'hA0 + 32'(c));
        end
        tick();
        check("multi_idle", 32'(if4.log_strobe), 32'h0);

        // Eight channels toggled faster than the log can drain.
        rst8 = 1'b0;
        for (int r = 0; r < 20; r++) begin
            pin8 = 8'hFF;
            repeat (6) tick();
            pin8 = 8'h00;
            repeat (6) tick();
        end
        check("overrun_set", 32'(if8.overrun), 32'h1);
        repeat (40) tick();
        check("overrun_sticky", 32'(if8.overrun), 32'h1);
        check("drained", 32'(if8.log_strobe), 32'h0);
        check("order_up_first", 32'(order_err8), 32'h0);
        check("tag_format", 32'(tag_err8), 32'h0);
        check("events_logged", 32'(strobes8 > 20), 32'h1);
        if8.overrun_clear = 1'b1;
        tick();
        if8.overrun_clear = 1'b0;
        check("overrun_cleared", 32'(if8.overrun), 32'h0);
        tick();
        check("overrun_stays_clear", 32'(if8.overrun), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/spi_power_seq.md
# spi_power_seq

Parametrised power-detect and reset sequencer for up to 8 emulated SPI flash targets. It is the generalised successor to the single-channel power-pin synchroniser and reset-hold counter in the ULX3S top level. Per channel, it synchronises the target-power pin and holds that channel's `spi_reset` until power has been stable for a programmable time. It optionally filters short power drops, and reports every power-up/power-down event as a byte on a log strobe interface for the glue/UART path.

## Interface
Parameters:
- `CHANNELS`, 1: number of SPI target channels, 1..8.
- `SYNC_STAGES`, 2: flops in each power-pin synchroniser, ≥2.
- `HOLD_CYCLES`, 65536: cycles of stable power before `spi_reset` releases (≈0.49 ms at 133 MHz), ≥2.
- `DROP_CYCLES`, 16: consecutive low samples needed to declare power lost (glitch filter only), ≥2.

Ports:
- `clk`  in  1  system clock (133 MHz in the flash emulator).
- `reset`  in  1  synchronous, active-high reset.
- `spi_power_in`  in  CHANNELS  asynchronous target-power pins.
- `spi_reset`  out  CHANNELS  per-channel reset to `spi_trx`; 1 = held in reset.
- `spi_power_ok`  out  CHANNELS  synchronised power level (last sync stage).
- `log_strobe`  out  1  one-cycle event strobe.
- `log_val`  out  8  event byte, valid with `log_strobe`.
- `overrun`  out  1  sticky flag: an event was lost.
- `overrun_clear`  in  1  clears `overrun`.

## Operation
- Per-channel synchroniser; `p` = its last stage.
- Per-channel FSM with states OFF, RAMP, ON, DROP and a counter wide enough for `max(HOLD_CYCLES, DROP_CYCLES)`:
  - OFF: if p=1 → RAMP, count=0.
  - RAMP: if p=0 → OFF. Else if count==HOLD_CYCLES-1 → ON, raising an up event. Else count+1.
  - ON: if p=0 → DROP, count=0 (filter built). Without the filter → OFF, raising a down event.
  - DROP: if p=1 → ON, with no event. Else if count==DROP_CYCLES-1 → OFF, raising a down event. Else count+1.
- `spi_reset[i]` = state is OFF or RAMP. It is a decode of registered state, with no combinational path from the pins.
- Events set per-channel `pend_up` / `pend_dn` bits on the same edge as the state change.
- Arbiter, one event per cycle:
  - Lowest channel index first.
  - Within a channel, up before down.
  - Registered `log_strobe` / `log_val`; the granted pending bit clears on the same edge.
- `log_val` = {2'b10, up, 2'b00, chan[2:0]}. The tag 10 distinguishes these bytes from `spi_trx` log bytes.
- Set/clear collision on the same bit and same edge: the bit stays set, because the new event wins.
- Set on an already-set bit that is not being granted: the event is dropped and `overrun` ← 1.
- `overrun_clear` clears `overrun` unless a new overrun occurs on the same edge; the new overrun wins.
- A drop in RAMP produces no event, because no up event was ever issued.

## Timing
- Reset values:
  - `spi_reset` = all 1.
  - `spi_power_ok`, `log_strobe`, `log_val`, `overrun` = 0.
  - All FSMs OFF, counters and pending bits 0, synchronisers 0.
- Reset mid-operation forces these values on the next edge and emits no events. Pending events are discarded.
- Pin rise to `spi_reset` fall: SYNC_STAGES + HOLD_CYCLES + 1 edges, with the pin stable throughout.
- The up event's `log_strobe` rises 1 edge after the edge where `spi_reset` falls, provided no contention.
- Pin fall to `spi_reset` rise:
  - SYNC_STAGES + DROP_CYCLES + 1 edges with the filter.
  - SYNC_STAGES + 1 edges without it.
- Worst-case drain: 2·CHANNELS cycles after the last event.

## Configuration
- `SPI_PWR_GLITCH_FILTER_EN`:
  - Defined: DROP state present. Power lows shorter than DROP_CYCLES synchronised samples are ignored, and `spi_reset` stays 0.
  - Undefined: no DROP state, and `DROP_CYCLES` is unused. Any synchronised low in ON → OFF on the next edge, with a down event.

## Test plan
- CHANNELS=1, SYNC_STAGES=2, HOLD_CYCLES=8, reset released, pin raised → `spi_reset` falls exactly 11 edges later. `log_strobe` fires 1 edge after that with `log_val`=8'hA0.
- Same config, pin dropped for 5 cycles in RAMP, then high → no event. The hold restarts, and `spi_reset` falls 11 edges after the second rise.
- Filter built, DROP_CYCLES=16:
  - 10-cycle low in ON → `spi_reset` stays 0, no log.
  - 40-cycle low → `spi_reset` rises 19 edges after the pin fall, `log_val`=8'h80.
- CHANNELS=4, all pins raised on the same edge → 4 strobes on consecutive cycles with `log_val` 8'hA0, 8'hA1, 8'hA2, 8'hA3.
- CHANNELS=8, filter undefined, HOLD_CYCLES=2, all channels toggled faster than the drain rate → `overrun`=1 and stays 1 until `overrun_clear`. Logged events never include a down event for a channel before that channel's up event.
- Synchronous `reset` asserted while channel 0 is ON and events are pending → the next edge gives `spi_reset`=all 1 and `log_strobe`=0, with no further strobes. After release with the pin still high, the full hold time repeats.
